// File: rtl/udp_tx_arb.sv
// udp_tx_arb: round-robin frame arbiter sharing one UDP TX header+payload
// port among S_COUNT sources. A grant is taken on a header handshake and
// held until the payload tlast beat is accepted.
// Ports: clk, rst (async, active low); s_udp_* per-source header/payload
// (packed, source i at [W*i +: W]); m_udp_* shared output; m_select,
// busy, error_timeout status.
// Optional: `define UDP_TX_ARB_TIMEOUT_EN adds a payload stall timeout.
module udp_tx_arb #(
  parameter int S_COUNT        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SW            = $clog2(S_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_COUNT-1:0]    s_udp_hdr_valid,
  output logic [S_COUNT-1:0]    s_udp_hdr_ready,
  input  logic [S_COUNT*32-1:0] s_udp_ip_dest_ip,
  input  logic [S_COUNT*16-1:0] s_udp_source_port,
  input  logic [S_COUNT*16-1:0] s_udp_dest_port,
  input  logic [S_COUNT*16-1:0] s_udp_length,
  input  logic [S_COUNT*8-1:0]  s_udp_payload_axis_tdata,
  input  logic [S_COUNT-1:0]    s_udp_payload_axis_tvalid,
  input  logic [S_COUNT-1:0]    s_udp_payload_axis_tlast,
  input  logic [S_COUNT-1:0]    s_udp_payload_axis_tuser,
  output logic [S_COUNT-1:0]    s_udp_payload_axis_tready,
  output logic                  m_udp_hdr_valid,
  input  logic                  m_udp_hdr_ready,
  output logic [31:0]           m_udp_ip_dest_ip,
  output logic [15:0]           m_udp_source_port,
  output logic [15:0]           m_udp_dest_port,
  output logic [15:0]           m_udp_length,
  output logic [7:0]            m_udp_payload_axis_tdata,
  output logic                  m_udp_payload_axis_tvalid,
  output logic                  m_udp_payload_axis_tlast,
  output logic                  m_udp_payload_axis_tuser,
  input  logic                  m_udp_payload_axis_tready,
  output logic [SW-1:0]         m_select,
  output logic                  busy,
  output logic                  error_timeout
);

  if (S_COUNT < 2 || S_COUNT > 16) begin : g_bad_s
    $error("udp_tx_arb: S_COUNT must be 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_t
    $error("udp_tx_arb: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {
    IDLE, HDR, PAY, TERM, DRAIN
  } state_t;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {
    IDLE, HDR, PAY
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          hv_q, hv_d;
  logic [31:0]   ip_q, ip_d;
  logic [15:0]   sp_q, sp_d;
  logic [15:0]   dp_q, dp_d;
  logic [15:0]   len_q, len_d;

  logic [SW-1:0] win, idx, rr_nxt;
  logic          found;
  int            j;
  logic          sel_tvalid, sel_tlast, sel_tuser;
  logic [7:0]    sel_tdata;

  assign sel_tvalid = s_udp_payload_axis_tvalid[sel_q];
  assign sel_tlast  = s_udp_payload_axis_tlast[sel_q];
  assign sel_tuser  = s_udp_payload_axis_tuser[sel_q];
  assign sel_tdata  = s_udp_payload_axis_tdata[{sel_q, 3'd0} +: 8];
  assign rr_nxt     = (sel_q == SW'(S_COUNT-1)) ? '0 : sel_q + 1'b1;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      j = int'(rr_q) + k;
      if (j >= S_COUNT) j = j - S_COUNT;
      idx = SW'(j);
      if (!found && s_udp_hdr_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    hv_d    = hv_q;
    ip_d    = ip_q;
    sp_d    = sp_q;
    dp_d    = dp_q;
    len_d   = len_q;
    s_udp_hdr_ready           = '0;
    s_udp_payload_axis_tready = '0;
    m_udp_payload_axis_tdata  = '0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    error_timeout             = 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // rst gate keeps every ready low while reset is held.
        if (found && rst) begin
          s_udp_hdr_ready[win] = 1'b1;
          sel_d   = win;
          hv_d    = 1'b1;
          ip_d    = s_udp_ip_dest_ip[{win, 5'd0} +: 32];
          sp_d    = s_udp_source_port[{win, 4'd0} +: 16];
          dp_d    = s_udp_dest_port[{win, 4'd0} +: 16];
          len_d   = s_udp_length[{win, 4'd0} +: 16];
          state_d = HDR;
`ifdef UDP_TX_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      HDR: begin
        if (m_udp_hdr_ready) begin
          hv_d    = 1'b0;
          state_d = PAY;
        end
      end
      PAY: begin
        m_udp_payload_axis_tdata  = sel_tdata;
        m_udp_payload_axis_tvalid = sel_tvalid;
        m_udp_payload_axis_tlast  = sel_tlast;
        m_udp_payload_axis_tuser  = sel_tuser;
        s_udp_payload_axis_tready[sel_q] = m_udp_payload_axis_tready;
        if (sel_tvalid && m_udp_payload_axis_tready) begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (sel_tlast) begin
            state_d = IDLE;
            rr_d    = rr_nxt;
          end
        end
`ifdef UDP_TX_ARB_TIMEOUT_EN
        else if (!sel_tvalid) begin
          // TERM is presented in the cycle the count reaches the limit.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT_CYCLES-1)) state_d = TERM;
        end
`endif
      end
`ifdef UDP_TX_ARB_TIMEOUT_EN
      TERM: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tlast  = 1'b1;
        m_udp_payload_axis_tuser  = 1'b1;
        if (m_udp_payload_axis_tready) begin
          error_timeout = 1'b1;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        s_udp_payload_axis_tready[sel_q] = 1'b1;
        if (sel_tvalid && sel_tlast) begin
          state_d = IDLE;
          rr_d    = rr_nxt;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      hv_q    <= 1'b0;
      ip_q    <= '0;
      sp_q    <= '0;
      dp_q    <= '0;
      len_q   <= '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      hv_q    <= hv_d;
      ip_q    <= ip_d;
      sp_q    <= sp_d;
      dp_q    <= dp_d;
      len_q   <= len_d;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign m_udp_hdr_valid   = hv_q;
  assign m_udp_ip_dest_ip  = ip_q;
  assign m_udp_source_port = sp_q;
  assign m_udp_dest_port   = dp_q;
  assign m_udp_length      = len_q;
  assign m_select          = sel_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: self-checking bench for udp_tx_arb (S_COUNT=4).
// Source models feed a scoreboard; output handshakes pop and compare.
module tb_udp_tx_arb;
  localparam int S  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [S-1:0]    s_hv, s_hr, s_tv, s_tl, s_tu, s_tr;
  logic [S*32-1:0] s_ip;
  logic [S*16-1:0] s_sp, s_dp, s_len;
  logic [S*8-1:0]  s_td;
  logic            m_hv, m_hr, m_tv, m_tl, m_tu, m_tr;
  logic [31:0]     m_ip;
  logic [15:0]     m_sp, m_dp, m_len;
  logic [7:0]      m_td;
  logic [1:0]      m_sel;
  logic            busy, err;

  udp_tx_arb #(.S_COUNT(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_hv), .s_udp_hdr_ready(s_hr),
    .s_udp_ip_dest_ip(s_ip), .s_udp_source_port(s_sp),
    .s_udp_dest_port(s_dp), .s_udp_length(s_len),
    .s_udp_payload_axis_tdata(s_td),
    .s_udp_payload_axis_tvalid(s_tv),
    .s_udp_payload_axis_tlast(s_tl),
    .s_udp_payload_axis_tuser(s_tu),
    .s_udp_payload_axis_tready(s_tr),
    .m_udp_hdr_valid(m_hv), .m_udp_hdr_ready(m_hr),
    .m_udp_ip_dest_ip(m_ip), .m_udp_source_port(m_sp),
    .m_udp_dest_port(m_dp), .m_udp_length(m_len),
    .m_udp_payload_axis_tdata(m_td),
    .m_udp_payload_axis_tvalid(m_tv),
    .m_udp_payload_axis_tlast(m_tl),
    .m_udp_payload_axis_tuser(m_tu),
    .m_udp_payload_axis_tready(m_tr),
    .m_select(m_sel), .busy(busy), .error_timeout(err)
  );

  typedef struct {
    logic [31:0] ip;
    logic [15:0] sp, dp, len;
    int nb;
    int src;
  } hdr_t;
  typedef struct {
    logic [7:0] d;
    logic l;
    logic u;
  } beat_t;
  typedef struct {
    logic [3:0]  mask;
    int          nb;
    int          n;
    logic [15:0] order;
  } vec_t;

  hdr_t       hq[S][$];
  logic [7:0] bq[S][$];
  int         ph[S], rem[S];
  logic       stall[S];
  hdr_t       exp_h[$];
  beat_t      exp_b[$];
  int         grants[$];
  logic       eager = 1'b0;
  logic       hr_ctl = 1'b1;
  logic       tr_mode = 1'b0;
  logic       mirror_chk = 1'b0;
  logic       tmo_mode = 1'b0;
  logic       term_seen = 1'b0;
  int         term_cnt = 0, drained = 0, err_cnt = 0;
  int         tests = 0, fails = 0;
  vec_t       vt[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_frame(input int src, input logic [31:0] ip,
                           input logic [15:0] sp, input logic [15:0] dp,
                           input logic [15:0] len, input int nb,
                           input logic [7:0] seed);
    hdr_t h;
    h.ip = ip; h.sp = sp; h.dp = dp; h.len = len;
    h.nb = nb; h.src = src;
    hq[src].push_back(h);
    for (int k = 0; k < nb; k++) bq[src].push_back(seed + 8'(k));
  endtask

  task automatic clear_model();
    for (int i = 0; i < S; i++) begin
      hq[i].delete(); bq[i].delete();
      ph[i] = 0; rem[i] = 0; stall[i] = 1'b0;
    end
    exp_h.delete(); exp_b.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < S; i++) begin
      logic hp;
      int left;
      hp = (ph[i] == 0) && (hq[i].size() > 0);
      left = (ph[i] == 1) ? rem[i] : (hp ? hq[i][0].nb : 0);
      s_hv[i] = hp;
      if (hp) begin
        s_ip[32*i +: 32] = hq[i][0].ip;
        s_sp[16*i +: 16] = hq[i][0].sp;
        s_dp[16*i +: 16] = hq[i][0].dp;
        s_len[16*i +: 16] = hq[i][0].len;
      end
      s_tv[i] = ((ph[i] == 1) && !stall[i]) || (eager && hp);
      s_td[8*i +: 8] = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
      s_tl[i] = (left == 1);
      s_tu[i] = s_td[8*i+7];
    end
    m_hr = hr_ctl;
    m_tr = tr_mode ? ~m_tr : 1'b1;
  endtask

  task automatic sample();
    if (mirror_chk && busy && !m_hv && m_sel == 2'd1 && ph[1] == 1)
      chk("tready_mirror", s_tr, m_tr ? 4'b0010 : 4'b0000);
    tests++;
    if ($countones(s_hr) > 1 || (s_hr & ~s_hv) != '0 ||
        (s_tr & ~(4'b0001 << m_sel)) != '0) begin
      fails++;
      $display("FAIL ready_select: hdr_ready=%b tready=%b sel=%0d",
               s_hr, s_tr, m_sel);
    end
    if (err) err_cnt++;
    for (int i = 0; i < S; i++) begin
      if (s_hv[i] && s_hr[i]) begin
        hdr_t h;
        h = hq[i].pop_front();
        exp_h.push_back(h);
        ph[i] = 1; rem[i] = h.nb;
      end else if (s_tv[i] && s_tr[i]) begin
        if (ph[i] != 1) begin
          chk("early_tready", {60'd0, s_tr}, 64'd0);
        end else begin
          beat_t b;
          b.d = bq[i].pop_front();
          b.l = (rem[i] == 1);
          b.u = b.d[7];
          if (term_seen) begin
            chk("drain_m_tvalid", m_tv, 0);
            drained++;
          end else exp_b.push_back(b);
          rem[i]--;
          if (rem[i] == 0) ph[i] = 0;
        end
      end
    end
    if (m_hv && m_hr) begin
      if (exp_h.size() == 0) chk("spurious_hdr", 1, 0);
      else begin
        hdr_t h;
        h = exp_h.pop_front();
        chk("hdr_select", m_sel, h.src);
        chk("hdr_ip", m_ip, h.ip);
        chk("hdr_sport", m_sp, h.sp);
        chk("hdr_dport", m_dp, h.dp);
        chk("hdr_len", m_len, h.len);
        grants.push_back(int'(m_sel));
      end
    end
    if (m_tv && m_tr) begin
      if (tmo_mode && exp_b.size() == 0) begin
        chk("term_data", m_td, 0);
        chk("term_last", m_tl, 1);
        chk("term_user", m_tu, 1);
        term_seen = 1'b1;
        term_cnt++;
      end else if (exp_b.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        beat_t b;
        b = exp_b.pop_front();
        chk("pay_data", m_td, b.d);
        chk("pay_last", m_tl, b.l);
        chk("pay_user", m_tu, b.u);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    sample();
  endtask

  function automatic bit model_idle();
    for (int i = 0; i < S; i++)
      if (hq[i].size() != 0 || ph[i] != 0) return 1'b0;
    return exp_h.size() == 0 && exp_b.size() == 0 && !busy;
  endfunction

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (!model_idle() && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, n >= budget, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [15:0] grant_code();
    logic [15:0] g;
    g = '0;
    foreach (grants[k]) g = (g << 4) | 16'(grants[k]);
    return g;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b0001, 1, 1, 16'h0000};
    vt[1] = '{4'b0101, 2, 2, 16'h0020};
    vt[2] = '{4'b1111, 1, 4, 16'h1230};
    vt[3] = '{4'b1000, 3, 1, 16'h0003};
    vt[4] = '{4'b0110, 2, 2, 16'h0012};
    vt[5] = '{4'b1011, 1, 3, 16'h0301};

    clear_model();
    s_hv = '1; s_tv = '1; s_tl = '0; s_tu = '0;
    s_ip = '0; s_sp = '0; s_dp = '0; s_len = '0; s_td = '0;
    m_hr = 1'b1; m_tr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hdr_ready", s_hr, 0);
    chk("rst_tready", s_tr, 0);
    chk("rst_m_hdr_valid", m_hv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_select", m_sel, 0);
    chk("rst_fields", {m_ip, m_sp, m_len}, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive();

    // single frame with cycle-exact latency
    add_frame(1, 32'h0A000002, 16'd1234, 16'd5678, 16'd11, 3, 8'h41);
    tick();
    chk("sf_hdr_ready", s_hr, 4'b0010);
    chk("sf_busy_idle", busy, 0);
    tick();
    chk("sf_hdr_pulse", s_hr, 0);
    chk("sf_m_hdr_valid", m_hv, 1);
    chk("sf_ip", m_ip, 32'h0A000002);
    chk("sf_ports", {m_sp, m_dp}, {16'd1234, 16'd5678});
    chk("sf_len", m_len, 11);
    chk("sf_select", m_sel, 1);
    chk("sf_no_pay_in_hdr", {m_tv, s_tr}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sf_tvalid", m_tv, 1);
      chk("sf_byte", m_td, 8'h41 + 8'(k));
      chk("sf_tlast", m_tl, k == 2);
    end
    tick();
    chk("sf_busy_after", busy, 0);

    // round robin between sources 0 and 2
    reset_dut();
    grants.delete();
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 32'h0A000100, 16'd100, 16'd200, 16'd10, 2, 8'h60);
      add_frame(2, 32'h0A000300, 16'd300, 16'd400, 16'd10, 2, 8'hE0);
    end
    wait_done("rr02", 100);
    chk("rr02_order", grant_code(), 16'h0202);
    chk("rr02_count", grants.size(), 4);

    // table of simultaneous request masks
    for (int v = 0; v < 6; v++) begin
      grants.delete();
      for (int i = 0; i < S; i++)
        if (vt[v].mask[i])
          add_frame(i, {24'h0A0000, 8'(i)}, 16'(1000 + i),
                    16'(2000 + v), 16'(8 + vt[v].nb), vt[v].nb,
                    8'(40 * v + 16 * i + 8'h70));
      wait_done("tbl", 200);
      chk("tbl_order", grant_code(), vt[v].order);
      chk("tbl_count", grants.size(), vt[v].n);
    end

    // header backpressure
    hr_ctl = 1'b0;
    add_frame(0, 32'hC0A80001, 16'h1111, 16'h2222, 16'h0010, 3, 8'h90);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hb_valid", m_hv, 1);
      chk("hb_ip", m_ip, 32'hC0A80001);
      chk("hb_len", m_len, 16'h0010);
      chk("hb_tready", s_tr, 0);
      chk("hb_m_tvalid", m_tv, 0);
    end
    hr_ctl = 1'b1;
    wait_done("hb", 50);

    // payload backpressure with an eager competitor
    grants.delete();
    eager = 1'b1;
    tr_mode = 1'b1;
    mirror_chk = 1'b1;
    add_frame(1, 32'h0A0000AA, 16'd7, 16'd8, 16'd12, 4, 8'hA0);
    add_frame(2, 32'h0A0000BB, 16'd9, 16'd10, 16'd10, 2, 8'h30);
    wait_done("pb", 80);
    mirror_chk = 1'b0;
    tr_mode = 1'b0;
    eager = 1'b0;
    chk("pb_order", grant_code(), 16'h0012);

`ifdef UDP_TX_ARB_TIMEOUT_EN
    begin
      int n;
      tmo_mode = 1'b1;
      add_frame(0, 32'h0A0000CC, 16'd1, 16'd2, 16'd13, 5, 8'h21);
      n = 0;
      while (!(ph[0] == 1 && rem[0] == 3) && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_prefix", n >= 40, 0);
      stall[0] = 1'b1;
      n = 0;
      while (!term_seen && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_stall_cycles", n, TO);
      stall[0] = 1'b0;
      n = 0;
      while (ph[0] != 0 && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_drained", drained, 3);
      chk("tmo_term_cnt", term_cnt, 1);
      tick();
      chk("tmo_idle", busy, 0);
      tmo_mode = 1'b0;
      term_seen = 1'b0;
      grants.delete();
      add_frame(1, 32'h0A0000DD, 16'd3, 16'd4, 16'd9, 1, 8'h05);
      wait_done("tmo_next", 40);
      chk("tmo_next_grant", grant_code(), 16'h0001);
    end
    chk("err_pulses", err_cnt, 1);
`else
    chk("err_pulses", err_cnt, 0);
`endif

    // asynchronous reset in the middle of a payload
    begin
      int n;
      add_frame(0, 32'h0A000010, 16'd11, 16'd12, 16'd12, 4, 8'h10);
      n = 0;
      while (!(ph[0] == 1 && rem[0] == 3) && n < 40) begin
        tick();
        n++;
      end
      chk("mr_prefix", n >= 40, 0);
      add_frame(3, 32'h0A000033, 16'd33, 16'd34, 16'd9, 2, 8'h50);
      @(posedge clk);
      #1 drive();
      #1 rst = 1'b0;
      #1;
      chk("mr_hdr_ready", s_hr, 0);
      chk("mr_tready", s_tr, 0);
      chk("mr_valids", {m_hv, m_tv}, 0);
      chk("mr_busy", busy, 0);
      hq[0].delete(); bq[0].delete();
      ph[0] = 0; rem[0] = 0;
      exp_h.delete(); exp_b.delete();
      @(negedge clk);
      sample();
      tick();
      grants.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      drive();
      @(negedge clk);
      chk("mr_new_hdr_ready", s_hr, 4'b1000);
      sample();
      wait_done("mr", 40);
      chk("mr_grant", grant_code(), 16'h0003);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
